// File: rtl/mul_23_recon_if.sv
// Operand/result handshake bundle for the divide-by-23 reconstruction block.
// master drives operands and out_ready; slave is the reconstruction pipeline.
interface mul_23_recon_if;
  logic [27:0] IN_Q;
  logic [4:0]  IN_R;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X_out;
  logic        ovf_out;
  logic        rerr_out;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output IN_Q, IN_R, in_valid, out_ready,
    input  in_ready, X_out, ovf_out, rerr_out, out_valid
  );

  modport slave (
    input  IN_Q, IN_R, in_valid, out_ready,
    output in_ready, X_out, ovf_out, rerr_out, out_valid
  );
endinterface

// File: rtl/mul_23_recon.sv
// 3-stage valid/ready pipeline computing X = Q*23 + R (inverse of the /23 divider).
// Define MUL23_REM_CHECK_EN to flag remainders >= 23 on rerr_out.
module mul_23_recon (
  input logic           clk,
  input logic           rst_n,
  mul_23_recon_if.slave bus
);
  logic        v1, v2, v3;
  logic        en1, en2, en3;
  logic [27:0] q1;
  logic [4:0]  r1;
  logic [32:0] a2;
  logic [30:0] b2;
  logic [32:0] s3;

  assign en3 = ~v3 | bus.out_ready;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;

  assign bus.in_ready  = en1;
  assign bus.out_valid = v3;
  // s3 holds the exact sum; bit 32 is the carry past 32 bits
  assign bus.X_out     = s3[31:0];
  assign bus.ovf_out   = s3[32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      q1 <= '0;
      r1 <= '0;
      a2 <= '0;
      b2 <= '0;
      s3 <= '0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        q1 <= bus.IN_Q;
        r1 <= bus.IN_R;
      end
      if (en2) begin
        v2 <= v1;
        a2 <= ({5'b0, q1} << 4) + ({5'b0, q1} << 2);
        b2 <= ({3'b0, q1} << 1) + {3'b0, q1}
              + {26'b0, r1};
      end
      if (en3) begin
        v3 <= v2;
        s3 <= a2 + {2'b0, b2};
      end
    end
  end

`ifdef MUL23_REM_CHECK_EN
  logic rb1, rb2, rb3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rb1 <= 1'b0;
      rb2 <= 1'b0;
      rb3 <= 1'b0;
    end else begin
      if (en1) rb1 <= (bus.IN_R >= 5'd23);
      if (en2) rb2 <= rb1;
      if (en3) rb3 <= rb2;
    end
  end

  assign bus.rerr_out = rb3;
`else
  assign bus.rerr_out = 1'b0;
`endif
endmodule

// File: tb/tb_mul_23_recon.sv
// Randomized self-checking bench for mul_23_recon.
// Reference: in-flight queue of exact Q*23+R values tagged with accept cycle.
module tb_mul_23_recon;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;

  mul_23_recon_if bus ();

  mul_23_recon dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [32:0] s;
    logic        rb;
    int          t;
  } ent_t;

  ent_t sb[$];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic ent_t model(input logic [27:0] q,
                                 input logic [4:0] r);
    ent_t e;
    longint unsigned x;
    x = longint'(q) * 23 + longint'(r);
    e.s = x[32:0];
`ifdef MUL23_REM_CHECK_EN
    e.rb = (r >= 23);
`else
    e.rb = 1'b0;
`endif
    e.t = cyc;
    return e;
  endfunction

  // One cycle: drive at negedge, then judge both handshakes
  task automatic step(input logic iv, input logic [27:0] q,
                      input logic [4:0] r, input logic ordy);
    logic ev;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.IN_Q      = q;
    bus.IN_R      = r;
    bus.out_ready = ordy;
    #1;
    check("in_ready", bus.in_ready,
          ((sb.size() < 3) || ordy) ? 1 : 0);
    ev = (sb.size() > 0) && (cyc - sb[0].t >= 3);
    check("out_valid", bus.out_valid, ev);
    if (bus.out_valid && sb.size() > 0) begin
      check("X_out", bus.X_out, sb[0].s[31:0]);
      check("ovf_out", bus.ovf_out, sb[0].s[32]);
      check("rerr_out", bus.rerr_out, sb[0].rb);
      if (ordy) void'(sb.pop_front());
    end
    if (iv && bus.in_ready) sb.push_back(model(q, r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_X_out", bus.X_out, 0);
    check("rst_ovf", bus.ovf_out, 0);
    check("rst_rerr", bus.rerr_out, 0);
    check("rst_in_ready", bus.in_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++)
      step(1'b0, '0, '0, 1'b1);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] x;
    logic [27:0] q;
    bus.in_valid  = 1'b0;
    bus.IN_Q      = '0;
    bus.IN_R      = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // single operand, latency 3
    step(1'b1, 28'h1, 5'd5, 1'b1);
    repeat (4) step(1'b0, '0, '0, 1'b1);
    check("single_done", sb.size(), 0);

    // back-to-back stream
    for (int i = 0; i < 1000; i++)
      step(1'b1, 28'(i), 5'(i % 23), 1'b1);
    drain();

    // extreme operand: sets ovf
    step(1'b1, 28'hFFFFFFF, 5'd31, 1'b1);
    drain();

    // backpressure: 4 pushes, 3 held, then one release
    for (int i = 0; i < 4; i++)
      step(1'b1, 28'(100 + i), 5'(i), 1'b0);
    check("bp_held", sb.size(), 3);
    step(1'b1, 28'd200, 5'd7, 1'b0);
    step(1'b1, 28'd201, 5'd8, 1'b1);
    check("bp_swap", sb.size(), 3);
    step(1'b0, '0, '0, 1'b0);
    drain();

    // randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      q = 28'($urandom);
      if ($urandom_range(0, 15) == 0) q = 28'hFFFFFFF;
      step(1'($urandom_range(0, 3) != 0), q,
           5'($urandom_range(0, 31)),
           1'($urandom_range(0, 2) != 0));
    end
    drain();

    // reset with two operands in flight
    step(1'b1, 28'd11, 5'd1, 1'b1);
    step(1'b1, 28'd12, 5'd2, 1'b1);
    do_reset();
    repeat (5) step(1'b0, '0, '0, 1'b1);

    // round trip from the divider: X -> (X/23, X%23)
    for (int i = 0; i < 2000; i++) begin
      x = $urandom;
      step(1'b1, 28'(x / 23), 5'(x % 23),
           1'($urandom_range(0, 4) != 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
